axi4_lite_csr_master: RTL
=========================

AXI4_LITE_CSR_MASTER -- requirements
Module: axi4_lite_csr_master

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 256: maximum cycles spent waiting for a B or R beat; legal range 2..65535.
REQ-002 clk_i  input  1  clock; all logic on rising edge.
REQ-003 rst_i  input  1  reset, asynchronous, active-high.
REQ-004 cmd_valid_i  input  1  command request.
REQ-005 cmd_ready_o  output  1  command accepted when cmd_valid_i && cmd_ready_o.
REQ-006 cmd_wr_i  input  1  1 = write, 0 = read.
REQ-007 cmd_addr_i  input  32  byte address; bits [1:0] forwarded unchanged.
REQ-008 cmd_wdata_i  input  32  write data; ignored for reads.
REQ-009 cmd_wstrb_i  input  4  write strobes; ignored for reads.
REQ-010 rsp_valid_o  output  1  response available.
REQ-011 rsp_ready_i  input  1  response consumed when rsp_valid_o && rsp_ready_i.
REQ-012 rsp_rdata_o  output  32  read data; 0 for writes and on timeout.
REQ-013 rsp_resp_o  output  2  bresp/rresp as received; 2'b10 on timeout.
REQ-014 rsp_timeout_o  output  1  1 = no B/R beat within TIMEOUT_CYCLES.
REQ-015 csr_o  axi4_lite_if.master  --  AXI4-Lite initiator port, 32-bit address and data.

Function
REQ-016 The FSM SHALL use the states IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP and RSP.
REQ-017 cmd_ready_o SHALL be 1 only in IDLE with both orphan flags clear; on acceptance the address, data, strobe and direction are registered and the FSM moves to WR_REQ or RD_REQ.
REQ-018 awvalid and wvalid SHALL rise in the cycle after acceptance (WR_REQ), each drop independently after its own handshake, and never drop before its handshake; when both handshakes are done the FSM goes to WR_RESP.
REQ-019 In RD_REQ, arvalid SHALL be held until arready; the FSM then goes to RD_RESP.
REQ-020 bready SHALL be 1 in WR_RESP and rready 1 in RD_RESP; on the handshake the FSM latches bresp, or rresp and rdata, and goes to RSP.
REQ-021 In RSP, rsp_valid_o SHALL be 1 with stable payload until rsp_ready_i; the FSM then returns to IDLE, so at most one transaction is outstanding.
REQ-022 A 16-bit wait counter SHALL clear on entry to WR_RESP/RD_RESP and increment each cycle there; on reaching TIMEOUT_CYCLES-1 without a handshake the FSM goes to RSP with rsp_timeout_o=1, rsp_resp_o=2'b10, rsp_rdata_o=0.
REQ-023 Timeout from WR_RESP/RD_RESP SHALL set orphan_b/orphan_r; while a flag is set, bready/rready is held 1, the next B/R beat is discarded and clears the flag, and no response is generated.
REQ-024 A B or R handshake in the same cycle as timeout expiry SHALL count as a normal completion (handshake wins), with no orphan flag set.
REQ-025 No timeout SHALL apply in WR_REQ/RD_REQ; AW/W/AR valid is never withdrawn.
REQ-026 awprot/arprot SHALL be 3'b000; all AXI outputs SHALL be registered.

Reset
REQ-027 On reset, the FSM SHALL be in IDLE; awvalid, wvalid, arvalid, bready, rready, rsp_valid_o, rsp_timeout_o and both orphan flags SHALL be 0; rsp_rdata_o, rsp_resp_o and the counter SHALL be 0; cmd_ready_o SHALL be 1 after reset release.
REQ-028 Reset mid-transaction SHALL abandon it with no response; orphan flags are not preserved.

Structure
REQ-029 The state enum and the AXI4-Lite response constants (OKAY=2'b00, SLVERR=2'b10) SHALL live in package axi4_lite_csr_master_pkg.
REQ-030 The block SHALL be a single module; no sub-module.

Verification
REQ-031 Write to 0x04 with data 0x1, wstrb 0xF, and a slave with awready=wready=1 and bvalid one cycle later -> awvalid/wvalid rise at T+1, rsp_valid_o with resp 2'b00, timeout 0, rdata 0.
REQ-032 Slave asserts wready 3 cycles after awready -> awvalid drops after its handshake, wvalid is held until wready, exactly one AW and one W beat are issued.
REQ-033 Read of 0x08 with the slave returning 0xDEADBEEF, rresp 2'b00, and rsp_ready_i low for 5 cycles -> rsp payload is stable for 5 cycles, cmd_ready_o=0 until consumed.
REQ-034 TIMEOUT_CYCLES=16 and the slave never asserts bvalid -> response with timeout=1, resp 2'b10 after 16 cycles in WR_RESP; a late bvalid is consumed silently; the next cmd_ready_o rises only afterwards.
REQ-035 bvalid arrives on the expiry cycle -> normal response with timeout=0 and no orphan flag set.
REQ-036 rst_i pulsed while in RD_RESP -> all valids and readies are 0 immediately, no rsp_valid_o, and the FSM is in IDLE.

Source files
------------

// File: rtl/axi4_lite_csr_master_pkg.sv
// Shared types and constants for the AXI4-Lite CSR initiator.
package axi4_lite_csr_master_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_REQ  = 3'd3,
    RD_RESP = 3'd4,
    RSP     = 3'd5
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/axi4_lite_csr_master.sv
// Single-outstanding AXI4-Lite initiator turning cmd requests into AW/W/B or AR/R
// transactions, with a bounded wait for B/R beats and silent draining of late beats.
module axi4_lite_csr_master
  import axi4_lite_csr_master_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_wr_i,
  input  logic [31:0] cmd_addr_i,
  input  logic [31:0] cmd_wdata_i,
  input  logic [3:0]  cmd_wstrb_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic [1:0]  rsp_resp_o,
  output logic        rsp_timeout_o,
  output logic [31:0] csr_awaddr,
  output logic [2:0]  csr_awprot,
  output logic        csr_awvalid,
  input  logic        csr_awready,
  output logic [31:0] csr_wdata,
  output logic [3:0]  csr_wstrb,
  output logic        csr_wvalid,
  input  logic        csr_wready,
  input  logic [1:0]  csr_bresp,
  input  logic        csr_bvalid,
  output logic        csr_bready,
  output logic [31:0] csr_araddr,
  output logic [2:0]  csr_arprot,
  output logic        csr_arvalid,
  input  logic        csr_arready,
  input  logic [31:0] csr_rdata,
  input  logic [1:0]  csr_rresp,
  input  logic        csr_rvalid,
  output logic        csr_rready
);

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_n;
  logic [31:0] addr_q, addr_n;
  logic [31:0] wdata_q, wdata_n;
  logic [3:0]  wstrb_q, wstrb_n;
  logic        awvalid_q, awvalid_n;
  logic        wvalid_q, wvalid_n;
  logic        arvalid_q, arvalid_n;
  logic        bready_q, bready_n;
  logic        rready_q, rready_n;
  logic [15:0] cnt_q, cnt_n;
  logic        orphan_b_q, orphan_b_n;
  logic        orphan_r_q, orphan_r_n;
  logic        rsp_valid_q, rsp_valid_n;
  logic [31:0] rsp_rdata_q, rsp_rdata_n;
  logic [1:0]  rsp_resp_q, rsp_resp_n;
  logic        rsp_timeout_q, rsp_timeout_n;

  assign cmd_ready_o   = (state_q == IDLE) && !orphan_b_q && !orphan_r_q;

  assign csr_awaddr    = addr_q;
  assign csr_araddr    = addr_q;
  assign csr_wdata     = wdata_q;
  assign csr_wstrb     = wstrb_q;
  assign csr_awprot    = 3'b000;
  assign csr_arprot    = 3'b000;
  assign csr_awvalid   = awvalid_q;
  assign csr_wvalid    = wvalid_q;
  assign csr_arvalid   = arvalid_q;
  assign csr_bready    = bready_q;
  assign csr_rready    = rready_q;

  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_rdata_o   = rsp_rdata_q;
  assign rsp_resp_o    = rsp_resp_q;
  assign rsp_timeout_o = rsp_timeout_q;

  always_comb begin
    state_n       = state_q;
    addr_n        = addr_q;
    wdata_n       = wdata_q;
    wstrb_n       = wstrb_q;
    awvalid_n     = awvalid_q;
    wvalid_n      = wvalid_q;
    arvalid_n     = arvalid_q;
    bready_n      = bready_q;
    rready_n      = rready_q;
    cnt_n         = cnt_q;
    orphan_b_n    = orphan_b_q;
    orphan_r_n    = orphan_r_q;
    rsp_valid_n   = rsp_valid_q;
    rsp_rdata_n   = rsp_rdata_q;
    rsp_resp_n    = rsp_resp_q;
    rsp_timeout_n = rsp_timeout_q;

    // A beat belonging to a timed-out transaction is swallowed without a response.
    if (orphan_b_q && bready_q && csr_bvalid) begin
      orphan_b_n = 1'b0;
      bready_n   = 1'b0;
    end
    if (orphan_r_q && rready_q && csr_rvalid) begin
      orphan_r_n = 1'b0;
      rready_n   = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (cmd_valid_i && cmd_ready_o) begin
          addr_n  = cmd_addr_i;
          wdata_n = cmd_wdata_i;
          wstrb_n = cmd_wstrb_i;
          if (cmd_wr_i) begin
            awvalid_n = 1'b1;
            wvalid_n  = 1'b1;
            state_n   = WR_REQ;
          end else begin
            arvalid_n = 1'b1;
            state_n   = RD_REQ;
          end
        end
      end

      WR_REQ: begin
        if (awvalid_q && csr_awready) awvalid_n = 1'b0;
        if (wvalid_q && csr_wready)   wvalid_n  = 1'b0;
        if (!awvalid_n && !wvalid_n) begin
          bready_n = 1'b1;
          cnt_n    = '0;
          state_n  = WR_RESP;
        end
      end

      WR_RESP: begin
        // A handshake on the expiry cycle still completes normally.
        if (bready_q && csr_bvalid) begin
          bready_n      = 1'b0;
          rsp_valid_n   = 1'b1;
          rsp_rdata_n   = '0;
          rsp_resp_n    = csr_bresp;
          rsp_timeout_n = 1'b0;
          state_n       = RSP;
        end else if (cnt_q == TO_LAST) begin
          orphan_b_n    = 1'b1;
          rsp_valid_n   = 1'b1;
          rsp_rdata_n   = '0;
          rsp_resp_n    = RESP_SLVERR;
          rsp_timeout_n = 1'b1;
          state_n       = RSP;
        end else begin
          cnt_n = cnt_q + 16'd1;
        end
      end

      RD_REQ: begin
        if (arvalid_q && csr_arready) begin
          arvalid_n = 1'b0;
          rready_n  = 1'b1;
          cnt_n     = '0;
          state_n   = RD_RESP;
        end
      end

      RD_RESP: begin
        if (rready_q && csr_rvalid) begin
          rready_n      = 1'b0;
          rsp_valid_n   = 1'b1;
          rsp_rdata_n   = csr_rdata;
          rsp_resp_n    = csr_rresp;
          rsp_timeout_n = 1'b0;
          state_n       = RSP;
        end else if (cnt_q == TO_LAST) begin
          orphan_r_n    = 1'b1;
          rsp_valid_n   = 1'b1;
          rsp_rdata_n   = '0;
          rsp_resp_n    = RESP_SLVERR;
          rsp_timeout_n = 1'b1;
          state_n       = RSP;
        end else begin
          cnt_n = cnt_q + 16'd1;
        end
      end

      RSP: begin
        if (rsp_ready_i) begin
          rsp_valid_n = 1'b0;
          state_n     = IDLE;
        end
      end

      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      awvalid_q     <= 1'b0;
      wvalid_q      <= 1'b0;
      arvalid_q     <= 1'b0;
      bready_q      <= 1'b0;
      rready_q      <= 1'b0;
      cnt_q         <= '0;
      orphan_b_q    <= 1'b0;
      orphan_r_q    <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_resp_q    <= RESP_OKAY;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_n;
      addr_q        <= addr_n;
      wdata_q       <= wdata_n;
      wstrb_q       <= wstrb_n;
      awvalid_q     <= awvalid_n;
      wvalid_q      <= wvalid_n;
      arvalid_q     <= arvalid_n;
      bready_q      <= bready_n;
      rready_q      <= rready_n;
      cnt_q         <= cnt_n;
      orphan_b_q    <= orphan_b_n;
      orphan_r_q    <= orphan_r_n;
      rsp_valid_q   <= rsp_valid_n;
      rsp_rdata_q   <= rsp_rdata_n;
      rsp_resp_q    <= rsp_resp_n;
      rsp_timeout_q <= rsp_timeout_n;
    end
  end

endmodule
